spi_sclk_gen: RTL and testbench

Parametrised SPI serial-clock generator for the SPI master datapath. It produces SCLK for all four CPOL/CPHA modes with a runtime half-period divider and a runtime bit count. It also emits single-cycle load/shift/sample strobes that drive the shift register. A start/busy/done handshake and an abort input let the master FSM sequence transfers of 1..SPI_MAXLEN bits.

---
 rtl/spi_sclk_gen.sv | 192 +++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divided SCLK for all CPOL/CPHA modes plus
// load/shift/sample strobes and a start/busy/done/abort handshake.
module spi_sclk_gen #(
    parameter  int SPI_MAXLEN = 32,
    parameter  int DIV_W      = 16,
    localparam int NB_W       = $clog2(SPI_MAXLEN) + 1,
    localparam int K_W        = $clog2(2 * SPI_MAXLEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [NB_W-1:0]  n_bits,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err,
    output logic             load_stb,
    output logic             shift_stb,
    output logic             sample_stb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [K_W-1:0]   r_k, w_k_nxt;
    logic [NB_W-1:0]  r_n, w_n_nxt;
    logic             r_cpol, w_cpol_nxt;
    logic             r_cpha, w_cpha_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_aborted, w_aborted_nxt;
    logic             r_cfg_err, w_cfg_err_nxt;
    logic             r_load, w_load_nxt;
    logic             r_shift, w_shift_nxt;
    logic             r_sample, w_sample_nxt;

    logic [K_W-1:0]   w_k_inc;
    logic [K_W-1:0]   w_two_n;
    logic             w_tc;
    logic             w_len_ok;

    function automatic logic f_len_ok(input logic [NB_W-1:0] len);
        return (len != '0) && (len <= NB_W'(SPI_MAXLEN));
    endfunction

    assign w_k_inc  = r_k + K_W'(1);
    assign w_two_n  = K_W'({r_n, 1'b0});
    assign w_tc     = (r_cnt == r_div);
    assign w_len_ok = f_len_ok(n_bits);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_k_nxt       = r_k;
        w_n_nxt       = r_n;
        w_cpol_nxt    = r_cpol;
        w_cpha_nxt    = r_cpha;
        w_sclk_nxt    = r_sclk;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_cfg_err_nxt = 1'b0;
        w_load_nxt    = 1'b0;
        w_shift_nxt   = 1'b0;
        w_sample_nxt  = 1'b0;

        // Abort takes priority over any edge or completion in the same cycle.
        if ((r_state != S_IDLE) && abort) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_k_nxt       = '0;
            w_sclk_nxt    = r_cpol;
            w_busy_nxt    = 1'b0;
            w_aborted_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sclk_nxt = cpol;
                    w_busy_nxt = 1'b0;
                    if (start) begin
                        if (w_len_ok) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                            w_k_nxt     = '0;
                            w_div_nxt   = clk_div;
                            w_n_nxt     = n_bits;
                            w_cpol_nxt  = cpol;
                            w_cpha_nxt  = cpha;
                            w_busy_nxt  = 1'b1;
                            w_load_nxt  = 1'b1;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_tc) begin
                        w_cnt_nxt  = '0;
                        w_sclk_nxt = ~r_sclk;
                        w_k_nxt    = w_k_inc;
                        // Odd edge index = leading edge; first CPHA=1 bit comes from load_stb.
                        if (r_cpha) begin
                            w_shift_nxt  = w_k_inc[0] && (w_k_inc != K_W'(1));
                            w_sample_nxt = ~w_k_inc[0];
                        end else begin
                            w_shift_nxt  = ~w_k_inc[0] && (w_k_inc != w_two_n);
                            w_sample_nxt = w_k_inc[0];
                        end
                        if (w_k_inc == w_two_n) begin
                            w_state_nxt = S_TAIL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                S_TAIL: begin
                    if (w_tc) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_k_nxt     = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_sclk    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_cfg_err <= 1'b0;
            r_load    <= 1'b0;
            r_shift   <= 1'b0;
            r_sample  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_k       <= w_k_nxt;
            r_n       <= w_n_nxt;
            r_cpol    <= w_cpol_nxt;
            r_cpha    <= w_cpha_nxt;
            r_sclk    <= w_sclk_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_load    <= w_load_nxt;
            r_shift   <= w_shift_nxt;
            r_sample  <= w_sample_nxt;
        end
    end

    assign sclk       = r_sclk;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign cfg_err    = r_cfg_err;
    assign load_stb   = r_load;
    assign shift_stb  = r_shift;
    assign sample_stb = r_sample;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: per-cycle expected output vectors are queued from
// closed-form edge timing and compared at the falling clock edge.
module tb_spi_sclk_gen;

    localparam int MAXLEN = 32;
    localparam int DIV_W  = 16;
    localparam int NB_W   = $clog2(MAXLEN) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [DIV_W-1:0] clk_div = '0;
    logic [NB_W-1:0]  n_bits = '0;
    logic             cpol = 1'b0;
    logic             cpha = 1'b0;
    logic             sclk, busy, done, aborted, cfg_err;
    logic             load_stb, shift_stb, sample_stb;

    spi_sclk_gen #(.SPI_MAXLEN(MAXLEN), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .clk_div(clk_div), .n_bits(n_bits), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .busy(busy), .done(done), .aborted(aborted),
        .cfg_err(cfg_err), .load_stb(load_stb), .shift_stb(shift_stb),
        .sample_stb(sample_stb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    int   c_busy, c_sample, c_shift, c_load, c_done, c_ab, c_edges;
    logic prev_sclk;

    // Vector layout: {busy, sclk, load, shift, sample, done, aborted, cfg_err}
    function automatic logic [7:0] obs();
        return {busy, sclk, load_stb, shift_stb, sample_stb, done, aborted, cfg_err};
    endfunction

    function automatic void clear_tally();
        c_busy = 0; c_sample = 0; c_shift = 0; c_load = 0;
        c_done = 0; c_ab = 0; c_edges = 0; prev_sclk = sclk;
    endfunction

    function automatic void tally();
        c_busy   += int'(busy);
        c_sample += int'(sample_stb);
        c_shift  += int'(shift_stb);
        c_load   += int'(load_stb);
        c_done   += int'(done);
        c_ab     += int'(aborted);
        c_edges  += int'(sclk !== prev_sclk);
        prev_sclk = sclk;
    endfunction

    // t=1 is the first busy cycle; edge j (1..2n) lands at t = j*d + 1.
    task automatic push_xfer(input int n, input int div, input logic pol, input logic pha);
        int d, len, j, es;
        logic e, sa, sh;
        d   = div + 1;
        len = (2 * n + 1) * d;
        for (int t = 1; t <= len + 1; t++) begin
            j  = (t - 1) / d;
            e  = ((t - 1) % d == 0) && (j >= 1) && (j <= 2 * n);
            es = (j > 2 * n) ? 2 * n : j;
            sa = e && (pha ? (j % 2 == 0) : (j % 2 == 1));
            sh = e && (pha ? (j % 2 == 1 && j >= 3) : (j % 2 == 0 && j < 2 * n));
            exp_q.push_back({logic'(t <= len), pol ^ logic'(es % 2), logic'(t == 1),
                             sh, sa, logic'(t == len + 1), 2'b00});
        end
    endtask

    task automatic test_reset();
        logic [7:0] g;
        rst = 1'b0; cpol = 1'b1;
        repeat (3) @(negedge clk);
        g = obs();
        n_checks++;
        if (g !== 8'h00) $display("FAIL reset_vals got=%b want=%b", g, 8'h00); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sclk !== 1'b1) $display("FAIL idle_cpol1 got=%b want=1", sclk); else n_pass++;
        cpol = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sclk !== 1'b0) $display("FAIL idle_cpol0 got=%b want=0", sclk); else n_pass++;
    endtask

    task automatic test_mode0();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        clear_tally();
        clk_div = 1; n_bits = 2; start = 1'b1;
        push_xfer(2, 1, 1'b0, 1'b0);
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++; start = 1'b0;
            e = exp_q.pop_front(); g = obs(); tally();
            n_checks++;
            if (g !== e) $display("FAIL mode0 t=%0d got=%b want=%b", t, g, e); else n_pass++;
        end
        n_checks++;
        if (c_busy !== 10) $display("FAIL mode0_busy got=%0d want=10", c_busy); else n_pass++;
        n_checks++;
        if ({c_sample, c_shift, c_load, c_done} !== {32'd2, 32'd1, 32'd1, 32'd1})
            $display("FAIL mode0_counts got=%0d/%0d/%0d/%0d want=2/1/1/1", c_sample, c_shift, c_load, c_done);
        else n_pass++;
    endtask

    task automatic test_mode3();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b1; cpha = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sclk !== 1'b1) $display("FAIL mode3_idle got=%b want=1", sclk); else n_pass++;
        clear_tally();
        clk_div = 0; n_bits = 8; start = 1'b1;
        push_xfer(8, 0, 1'b1, 1'b1);
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++; start = 1'b0;
            e = exp_q.pop_front(); g = obs(); tally();
            n_checks++;
            if (g !== e) $display("FAIL mode3 t=%0d got=%b want=%b", t, g, e); else n_pass++;
        end
        n_checks++;
        if ({c_busy, c_shift, c_sample, c_edges} !== {32'd17, 32'd7, 32'd8, 32'd16})
            $display("FAIL mode3_counts got=%0d/%0d/%0d/%0d want=17/7/8/16", c_busy, c_shift, c_sample, c_edges);
        else n_pass++;
        n_checks++;
        if (sclk !== 1'b1) $display("FAIL mode3_end got=%b want=1", sclk); else n_pass++;
    endtask

    task automatic test_modes12();
        logic [7:0] e, g;
        logic [1:0] m;
        int t;
        for (int i = 0; i < 2; i++) begin
            m = (i == 0) ? 2'b01 : 2'b10;
            @(negedge clk); cpol = m[1]; cpha = m[0];
            @(negedge clk);
            clear_tally();
            clk_div = 2; n_bits = 3; start = 1'b1;
            push_xfer(3, 2, m[1], m[0]);
            t = 0;
            while (exp_q.size() > 0) begin
                @(negedge clk); t++; start = 1'b0;
                e = exp_q.pop_front(); g = obs(); tally();
                n_checks++;
                if (g !== e) $display("FAIL mode%0d t=%0d got=%b want=%b", m, t, g, e); else n_pass++;
            end
            n_checks++;
            if ({c_sample, c_shift} !== {32'd3, 32'd2})
                $display("FAIL mode%0d_counts got=%0d/%0d want=3/2", m, c_sample, c_shift);
            else n_pass++;
        end
    endtask

    task automatic test_cfg_err();
        logic [7:0] e, g;
        int bad[2];
        bad[0] = 0;
        bad[1] = MAXLEN + 1;
        @(negedge clk); cpol = 1'b1; cpha = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_bits = NB_W'(bad[i]); clk_div = 1; start = 1'b1;
            exp_q.push_back(8'b0100_0001);
            exp_q.push_back(8'b0100_0000);
            exp_q.push_back(8'b0100_0000);
            while (exp_q.size() > 0) begin
                @(negedge clk); start = 1'b0;
                e = exp_q.pop_front(); g = obs();
                n_checks++;
                if (g !== e) $display("FAIL cfg_err n=%0d got=%b want=%b", bad[i], g, e); else n_pass++;
            end
        end
    endtask

    task automatic test_maxlen();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        clear_tally();
        clk_div = 3; n_bits = NB_W'(MAXLEN); start = 1'b1;
        push_xfer(MAXLEN, 3, 1'b0, 1'b0);
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++; start = 1'b0;
            e = exp_q.pop_front(); g = obs(); tally();
            n_checks++;
            if (g !== e) $display("FAIL maxlen t=%0d got=%b want=%b", t, g, e); else n_pass++;
        end
        n_checks++;
        if ({c_edges, c_busy, c_sample, c_shift} !== {32'd64, 32'd260, 32'd32, 32'd31})
            $display("FAIL maxlen_counts got=%0d/%0d/%0d/%0d want=64/260/32/31", c_edges, c_busy, c_sample, c_shift);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        clear_tally();
        clk_div = 1; n_bits = 4; start = 1'b1;
        push_xfer(4, 1, 1'b0, 1'b0);
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        exp_q.push_back(8'b0000_0010);
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++; start = 1'b0; abort = 1'b0;
            e = exp_q.pop_front(); g = obs(); tally();
            n_checks++;
            if (g !== e) $display("FAIL abort t=%0d got=%b want=%b", t, g, e); else n_pass++;
            if (t == 7) abort = 1'b1;
            if (t == 8) begin
                start = 1'b1; clk_div = 0; n_bits = 1;
                push_xfer(1, 0, 1'b0, 1'b0);
            end
        end
        n_checks++;
        if ({c_ab, c_done, c_load} !== {32'd1, 32'd1, 32'd2})
            $display("FAIL abort_counts got=%0d/%0d/%0d want=1/1/2", c_ab, c_done, c_load);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        clk_div = 1; n_bits = 4; start = 1'b1;
        push_xfer(4, 1, 1'b0, 1'b0);
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++;
            if (t == 1) start = 1'b0;
            e = exp_q.pop_front(); g = obs();
            n_checks++;
            if (g !== e) $display("FAIL busy_start t=%0d got=%b want=%b", t, g, e); else n_pass++;
            if (t == 2) begin
                start = 1'b1; cpol = 1'b1; cpha = 1'b1; n_bits = 0; clk_div = 5;
            end
            if (t == 16) start = 1'b0;
        end
        @(negedge clk);
        g = obs();
        n_checks++;
        if (g !== 8'b0100_0000) $display("FAIL busy_start_idle got=%b want=%b", g, 8'b0100_0000); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] e, g;
        int t;
        @(negedge clk); cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        clk_div = 1; n_bits = 4; start = 1'b1;
        push_xfer(4, 1, 1'b0, 1'b0);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        t = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk); t++; start = 1'b0;
            e = exp_q.pop_front(); g = obs();
            n_checks++;
            if (g !== e) $display("FAIL rst_pre t=%0d got=%b want=%b", t, g, e); else n_pass++;
        end
        #2 rst = 1'b0;
        #1 g = obs();
        n_checks++;
        if (g !== 8'h00) $display("FAIL async_reset got=%b want=%b", g, 8'h00); else n_pass++;
        @(negedge clk); rst = 1'b1;
        clear_tally();
        repeat (20) begin
            @(negedge clk);
            tally();
        end
        n_checks++;
        if ({c_busy, c_done, c_ab, c_edges} !== {32'd0, 32'd0, 32'd0, 32'd0})
            $display("FAIL post_reset got=%0d/%0d/%0d/%0d want=0/0/0/0", c_busy, c_done, c_ab, c_edges);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_modes12();
        test_cfg_err();
        test_maxlen();
        test_abort();
        test_busy_start();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
